uart_rx_packet_decoder: RTL and testbench
=========================================

// Module: uart_rx_packet_decoder
// PURPOSE
//  Sits directly downstream of UART_RX: consumes its o_DATA_RX/o_RX_DATA_VALID byte stream.
//  Frames bytes into controller packets: SYNC, LEN, LEN payload bytes, CHK (XOR of LEN and payload).
//  Emits the validated payload plus one-cycle error pulses, feeding the controller command logic.
// PARAMETERS
//  c_SYNC_BYTE       8'hA5  packet start marker
//  c_MAX_PAYLOAD     4      max payload bytes (1..8); sets o_PKT_DATA width
//  c_TIMEOUT_CYCLES  8680   idle clocks allowed between bytes inside a packet (about 4 byte times at 217 clk/bit)
// PORTS
//  i_CLK            in   1                  system clock
//  i_RST_N          in   1                  asynchronous, active-low reset
//  i_DATA_RX        in   8                  byte from UART_RX; sampled only when i_RX_DATA_VALID=1
//  i_RX_DATA_VALID  in   1                  one-cycle byte strobe from UART_RX
//  o_PKT_DATA       out  8*c_MAX_PAYLOAD    payload; byte k at [8k+7:8k]; unused bytes zero
//  o_PKT_LEN        out  4                  payload length of the last good packet
//  o_PKT_VALID      out  1                  one-cycle pulse; o_PKT_DATA/o_PKT_LEN are new this cycle
//  o_CHK_ERR        out  1                  one-cycle pulse; checksum mismatch
//  o_LEN_ERR        out  1                  one-cycle pulse; LEN=0 or LEN>c_MAX_PAYLOAD
//  o_TIMEOUT_ERR    out  1                  one-cycle pulse; inter-byte timeout inside a packet
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, byte index/checksum/timer 0. Asynchronous, so reset mid-packet
//   discards partial data immediately.
//  FSM moves only on a cycle with i_RX_DATA_VALID=1, except the timeout abort.
//   IDLE:    byte==c_SYNC_BYTE -> LEN. Any other byte is ignored; stay in IDLE.
//   LEN:     1<=byte<=c_MAX_PAYLOAD -> store len, chk<=byte, idx<=0, go to PAYLOAD.
//            Otherwise pulse o_LEN_ERR and go to IDLE. That byte is NOT re-checked as SYNC.
//   PAYLOAD: shadow[idx]<=byte, chk<=chk^byte, idx++. When idx==len-1 -> CHK.
//            A byte equal to c_SYNC_BYTE is plain data here.
//   CHK:     byte==chk -> copy shadow to o_PKT_DATA (zero above len), o_PKT_LEN<=len, pulse o_PKT_VALID.
//            Otherwise pulse o_CHK_ERR and leave o_PKT_DATA/o_PKT_LEN unchanged. Both cases go to IDLE.
//  Latency: pulses and output updates are registered, so they appear the cycle after the valid strobe
//   of the deciding byte.
//  Outputs hold until the next good packet; a failed packet never corrupts the last good one.
//  Timeout: the timer clears on every strobe and counts only in LEN, PAYLOAD and CHK.
//   On reaching c_TIMEOUT_CYCLES-1: pulse o_TIMEOUT_ERR, go to IDLE.
//   The timer never counts in IDLE.
//   If a strobe arrives in the same cycle the timer expires, the strobe wins: byte processed, no timeout.
//  A packet may begin on the very next strobe after a decision (back-to-back packets, no gap needed).
//  At most one error/valid pulse per cycle; all pulses are mutually exclusive.
//  Widths: idx is 3 bits and o_PKT_LEN is 4 bits; the timer is $clog2(c_TIMEOUT_CYCLES) bits and
//   saturates (never wraps).
// STRUCTURE
//  Shared include uart_pkg.vh: c_SYNC_BYTE default, FSM state localparams
//   (IDLE=0, LEN=1, PAYLOAD=2, CHK=3), default c_CYCLES_PER_BIT=217.
//  One sub-module: uart_byte_timeout
//   - ports: i_CLK, i_RST_N, i_CLEAR, i_ENABLE, o_EXPIRED
//   - parameter c_TIMEOUT_CYCLES
//  Everything else (FSM, shadow register, checksum) lives in the top module.
// TESTING (bench drives UART_RX with WRITE_TO_RX at 217 clk/bit; checks decoder outputs)
//  1. A5 02 26 37 13 -> one o_PKT_VALID; o_PKT_LEN=2; o_PKT_DATA=32'h0000_3726; no error pulses.
//  2. A5 02 26 37 14 -> o_CHK_ERR once; o_PKT_DATA/o_PKT_LEN keep their values from test 1.
//  3. A5 00 and A5 05 (c_MAX_PAYLOAD=4) -> o_LEN_ERR each time. A following A5 01 A5 A4
//     -> o_PKT_VALID with o_PKT_DATA=32'h0000_00A5 (SYNC value accepted as payload).
//  4. A5 02 26, then line idle >c_TIMEOUT_CYCLES -> o_TIMEOUT_ERR once, FSM IDLE.
//     Next A5 01 37 36 -> o_PKT_VALID, data 8'h37.
//  5. Garbage 37 26 FF then case-1 packet -> garbage ignored, exactly one o_PKT_VALID, no errors.
//  6. Assert i_RST_N=0 mid-payload of case 1 -> all outputs 0 asynchronously. After release,
//     a full case-1 packet decodes correctly.

Source files
------------

// File: rtl/uart_rx_packet_decoder_pkg.sv
// Shared types and defaults for the UART packet decoder: FSM encoding, sync marker, bit timing.
package uart_rx_packet_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LEN     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_CHK     = 2'd3
    } state_t;

    localparam logic [7:0] c_SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int c_CYCLES_PER_BIT = 217;
    // Roughly four 10-bit byte times of silence before a packet is abandoned.
    localparam int c_TIMEOUT_DEFAULT = 4 * 10 * c_CYCLES_PER_BIT;

    function automatic logic len_in_range(input logic [7:0] len_byte, input int max_payload);
        return (len_byte != 8'd0) && (len_byte <= 8'(max_payload));
    endfunction

endpackage

// File: rtl/uart_byte_timeout.sv
// Inter-byte idle timer: counts while enabled, clears on each byte strobe, saturates at expiry.
module uart_byte_timeout #(
    parameter int c_TIMEOUT_CYCLES = 8680
) (
    input  logic i_CLK,
    input  logic i_RST_N,
    input  logic i_CLEAR,
    input  logic i_ENABLE,
    output logic o_EXPIRED
);

    localparam int W = (c_TIMEOUT_CYCLES > 1) ? $clog2(c_TIMEOUT_CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(c_TIMEOUT_CYCLES - 1);

    logic [W-1:0] count;

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            count <= '0;
        end else if (i_CLEAR || !i_ENABLE) begin
            count <= '0;
        end else if (count != LAST) begin
            count <= count + 1'b1;
        end
    end

    assign o_EXPIRED = i_ENABLE && (count == LAST);

endmodule

// File: rtl/uart_rx_packet_decoder.sv
// Frames the UART_RX byte stream into SYNC/LEN/payload/CHK packets and publishes validated payloads.
module uart_rx_packet_decoder
    import uart_rx_packet_decoder_pkg::*;
#(
    parameter logic [7:0] c_SYNC_BYTE      = c_SYNC_BYTE_DEFAULT,
    parameter int         c_MAX_PAYLOAD    = 4,
    parameter int         c_TIMEOUT_CYCLES = c_TIMEOUT_DEFAULT
) (
    input  logic                       i_CLK,
    input  logic                       i_RST_N,
    input  logic [7:0]                 i_DATA_RX,
    input  logic                       i_RX_DATA_VALID,
    output logic [8*c_MAX_PAYLOAD-1:0] o_PKT_DATA,
    output logic [3:0]                 o_PKT_LEN,
    output logic                       o_PKT_VALID,
    output logic                       o_CHK_ERR,
    output logic                       o_LEN_ERR,
    output logic                       o_TIMEOUT_ERR
);

    state_t     state, next_state;
    logic [3:0] len;
    logic [7:0] chk;
    logic [2:0] idx;
    logic [7:0] shadow [c_MAX_PAYLOAD];
    logic       expired, last_byte;
    logic       take_len, take_byte, pkt_good, chk_bad, len_bad, time_out;

    uart_byte_timeout #(
        .c_TIMEOUT_CYCLES(c_TIMEOUT_CYCLES)
    ) u_timeout (
        .i_CLK    (i_CLK),
        .i_RST_N  (i_RST_N),
        .i_CLEAR  (i_RX_DATA_VALID),
        .i_ENABLE (state != ST_IDLE),
        .o_EXPIRED(expired)
    );

    assign last_byte = ({1'b0, idx} == (len - 4'd1));

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) state <= ST_IDLE;
        else          state <= next_state;
    end

    // A strobe always takes priority over a timeout expiring in the same cycle.
    always_comb begin
        next_state = state;
        if (i_RX_DATA_VALID) begin
            case (state)
                ST_IDLE:    if (i_DATA_RX == c_SYNC_BYTE) next_state = ST_LEN;
                ST_LEN:     next_state = len_in_range(i_DATA_RX, c_MAX_PAYLOAD) ? ST_PAYLOAD : ST_IDLE;
                ST_PAYLOAD: if (last_byte) next_state = ST_CHK;
                ST_CHK:     next_state = ST_IDLE;
                default:    next_state = ST_IDLE;
            endcase
        end else if (expired) begin
            next_state = ST_IDLE;
        end
    end

    always_comb begin
        take_len  = 1'b0;
        take_byte = 1'b0;
        pkt_good  = 1'b0;
        chk_bad   = 1'b0;
        len_bad   = 1'b0;
        time_out  = 1'b0;
        if (i_RX_DATA_VALID) begin
            case (state)
                ST_LEN: begin
                    if (len_in_range(i_DATA_RX, c_MAX_PAYLOAD)) take_len = 1'b1;
                    else                                       len_bad  = 1'b1;
                end
                ST_PAYLOAD: take_byte = 1'b1;
                ST_CHK: begin
                    if (i_DATA_RX == chk) pkt_good = 1'b1;
                    else                  chk_bad  = 1'b1;
                end
                default: ;
            endcase
        end else if (expired) begin
            time_out = 1'b1;
        end
    end

    // Payload accumulates in a shadow copy so a bad packet never disturbs the published one.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            len           <= '0;
            chk           <= '0;
            idx           <= '0;
            for (int k = 0; k < c_MAX_PAYLOAD; k++) shadow[k] <= '0;
            o_PKT_DATA    <= '0;
            o_PKT_LEN     <= '0;
            o_PKT_VALID   <= 1'b0;
            o_CHK_ERR     <= 1'b0;
            o_LEN_ERR     <= 1'b0;
            o_TIMEOUT_ERR <= 1'b0;
        end else begin
            o_PKT_VALID   <= pkt_good;
            o_CHK_ERR     <= chk_bad;
            o_LEN_ERR     <= len_bad;
            o_TIMEOUT_ERR <= time_out;
            if (take_len) begin
                len <= i_DATA_RX[3:0];
                chk <= i_DATA_RX;
                idx <= '0;
            end
            if (take_byte) begin
                for (int k = 0; k < c_MAX_PAYLOAD; k++) begin
                    if (idx == 3'(k)) shadow[k] <= i_DATA_RX;
                end
                chk <= chk ^ i_DATA_RX;
                idx <= idx + 3'd1;
            end
            if (pkt_good) begin
                for (int k = 0; k < c_MAX_PAYLOAD; k++) begin
                    o_PKT_DATA[8*k +: 8] <= (4'(k) < len) ? shadow[k] : 8'h00;
                end
                o_PKT_LEN <= len;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_packet_decoder.sv
// Bench for uart_rx_packet_decoder: packet-level reference model with per-cycle compare plus directed literal checks.
module tb_uart_rx_packet_decoder;

    localparam int         MAXP = 4;
    localparam int         TO   = 8680;
    localparam logic [7:0] SYNC = 8'hA5;
    localparam int         GAP  = 12;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b1;
    logic [7:0]  data_rx = 8'h00;
    logic        rx_valid = 1'b0;
    logic [31:0] pkt_data;
    logic [3:0]  pkt_len;
    logic        pkt_valid, chk_err, len_err, timeout_err;

    always #5 clk = ~clk;

    uart_rx_packet_decoder #(
        .c_SYNC_BYTE     (SYNC),
        .c_MAX_PAYLOAD   (MAXP),
        .c_TIMEOUT_CYCLES(TO)
    ) dut (
        .i_CLK          (clk),
        .i_RST_N        (rst_n),
        .i_DATA_RX      (data_rx),
        .i_RX_DATA_VALID(rx_valid),
        .o_PKT_DATA     (pkt_data),
        .o_PKT_LEN      (pkt_len),
        .o_PKT_VALID    (pkt_valid),
        .o_CHK_ERR      (chk_err),
        .o_LEN_ERR      (len_err),
        .o_TIMEOUT_ERR  (timeout_err)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: collects the bytes after SYNC and decides once the packet is complete.
    logic [31:0] m_data  = '0;
    logic [3:0]  m_len   = '0;
    logic        m_valid = 1'b0, m_chk = 1'b0, m_lenerr = 1'b0, m_to = 1'b0;
    bit          in_pkt  = 1'b0;
    int          idle_cnt = 0;
    logic [7:0]  cur[$];
    logic [7:0]  xsum;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data = '0; m_len = '0;
            m_valid = 1'b0; m_chk = 1'b0; m_lenerr = 1'b0; m_to = 1'b0;
            in_pkt = 1'b0; idle_cnt = 0;
            cur.delete();
        end else begin
            m_valid = 1'b0; m_chk = 1'b0; m_lenerr = 1'b0; m_to = 1'b0;
            if (rx_valid) begin
                idle_cnt = 0;
                if (!in_pkt) begin
                    if (data_rx == SYNC) begin
                        in_pkt = 1'b1;
                        cur.delete();
                    end
                end else begin
                    cur.push_back(data_rx);
                    if (cur.size() == 1) begin
                        if (data_rx == 8'd0 || int'(data_rx) > MAXP) begin
                            m_lenerr = 1'b1;
                            in_pkt   = 1'b0;
                        end
                    end else if (cur.size() == int'(cur[0]) + 2) begin
                        xsum = 8'h00;
                        for (int i = 0; i < cur.size() - 1; i++) xsum = xsum ^ cur[i];
                        if (xsum == data_rx) begin
                            m_data = '0;
                            for (int i = 0; i < int'(cur[0]); i++) m_data[8*i +: 8] = cur[i+1];
                            m_len   = cur[0][3:0];
                            m_valid = 1'b1;
                        end else begin
                            m_chk = 1'b1;
                        end
                        in_pkt = 1'b0;
                    end
                end
            end else if (in_pkt) begin
                idle_cnt++;
                if (idle_cnt == TO) begin
                    m_to   = 1'b1;
                    in_pkt = 1'b0;
                end
            end
        end
    end

    int n_valid = 0, n_chk = 0, n_len = 0, n_to = 0;

    always @(negedge clk) begin
        check("pkt_data",    pkt_data,           m_data);
        check("pkt_len",     32'(pkt_len),       32'(m_len));
        check("pkt_valid",   32'(pkt_valid),     32'(m_valid));
        check("chk_err",     32'(chk_err),       32'(m_chk));
        check("len_err",     32'(len_err),       32'(m_lenerr));
        check("timeout_err", 32'(timeout_err),   32'(m_to));
        check("pulse_excl",  32'(int'(pkt_valid) + int'(chk_err) + int'(len_err) + int'(timeout_err) > 1), 32'd0);
        if (rst_n) begin
            n_valid += int'(pkt_valid);
            n_chk   += int'(chk_err);
            n_len   += int'(len_err);
            n_to    += int'(timeout_err);
        end
    end

    int b_valid, b_chk, b_len, b_to;

    task automatic snap();
        b_valid = n_valid; b_chk = n_chk; b_len = n_len; b_to = n_to;
    endtask

    task automatic check_counts(input string tag, input int v, input int c, input int l, input int t);
        check({tag, "_valid_cnt"},   32'(n_valid - b_valid), 32'(v));
        check({tag, "_chk_cnt"},     32'(n_chk - b_chk),     32'(c));
        check({tag, "_len_cnt"},     32'(n_len - b_len),     32'(l));
        check({tag, "_timeout_cnt"}, 32'(n_to - b_to),       32'(t));
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk); #1;
        data_rx  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        data_rx  = 8'h00;
        repeat (GAP) @(posedge clk);
        #1;
    endtask

    task automatic send_case1();
        send(8'hA5); send(8'h02); send(8'h26); send(8'h37); send(8'h13);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_data", pkt_data, 32'h0);
        check("reset_len", 32'(pkt_len), 32'h0);
        check("reset_pulses", {28'h0, pkt_valid, chk_err, len_err, timeout_err}, 32'h0);
        rst_n = 1'b1;

        snap();
        send_case1();
        check_counts("t1", 1, 0, 0, 0);
        check("t1_data", pkt_data, 32'h0000_3726);
        check("t1_len", 32'(pkt_len), 32'd2);

        snap();
        send(8'hA5); send(8'h02); send(8'h26); send(8'h37); send(8'h14);
        check_counts("t2", 0, 1, 0, 0);
        check("t2_data_kept", pkt_data, 32'h0000_3726);
        check("t2_len_kept", 32'(pkt_len), 32'd2);

        snap();
        send(8'hA5); send(8'h00);
        send(8'hA5); send(8'h05);
        check_counts("t3a", 0, 0, 2, 0);
        check("t3a_data_kept", pkt_data, 32'h0000_3726);
        snap();
        send(8'hA5); send(8'h01); send(8'hA5); send(8'hA4);
        check_counts("t3b", 1, 0, 0, 0);
        check("t3b_data", pkt_data, 32'h0000_00A5);
        check("t3b_len", 32'(pkt_len), 32'd1);

        snap();
        send(8'hA5); send(8'h02); send(8'h26);
        repeat (TO + 20) @(posedge clk);
        #1;
        check_counts("t4a", 0, 0, 0, 1);
        check("t4a_data_kept", pkt_data, 32'h0000_00A5);
        snap();
        send(8'hA5); send(8'h01); send(8'h37); send(8'h36);
        check_counts("t4b", 1, 0, 0, 0);
        check("t4b_data", pkt_data, 32'h0000_0037);

        snap();
        send(8'h37); send(8'h26); send(8'hFF);
        send_case1();
        check_counts("t5", 1, 0, 0, 0);
        check("t5_data", pkt_data, 32'h0000_3726);

        send(8'hA5); send(8'h02); send(8'h26);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("t6_async_data", pkt_data, 32'h0);
        check("t6_async_len", 32'(pkt_len), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        snap();
        send_case1();
        check_counts("t6", 1, 0, 0, 0);
        check("t6_data", pkt_data, 32'h0000_3726);
        check("t6_len", 32'(pkt_len), 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
